// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
package scan_pkg;

  localparam int SEL_WIDTH = 2;
  localparam int NUM_CH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_next_sel.sv
// Combinational search for the next enabled channel, used both for the
// first channel of a sweep (i_first=1, search from 0) and at every dwell end.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0]    i_mask,
  input  logic [SEL_WIDTH-1:0] i_sel,
  input  logic                 i_first,
  output logic [SEL_WIDTH-1:0] o_next,
  output logic                 o_wrap,
  output logic                 o_none
);

  logic [SEL_WIDTH-1:0] w_base;
  logic [SEL_WIDTH-1:0] w_idx;
  logic                 w_found;

  always_comb begin
    w_base  = i_first ? '0 : i_sel + SEL_WIDTH'(1);
    w_idx   = '0;
    w_found = 1'b0;
    o_next  = i_sel;
    // Index arithmetic is SEL_WIDTH bits wide, so base+k wraps modulo NUM_CH.
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = w_base + SEL_WIDTH'(k);
      if (!w_found && i_mask[w_idx]) begin
        o_next  = w_idx;
        w_found = 1'b1;
      end
    end
    o_none = ~|i_mask;
    o_wrap = i_first | (o_next <= i_sel);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scans a 2-bit channel select across the unmasked channels, holding each for
// i_period+1 cycles. Define SCAN_BLANK_EN to insert one en=0 cycle between dwells.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [DIV_WIDTH-1:0] i_period,
  input  logic [NUM_CH-1:0]    i_mask,
  output logic [SEL_WIDTH-1:0] o_sel,
  output logic                 o_en,
  output logic                 o_busy,
  output logic                 o_wrap,
  output logic [1:0]           o_state
);

  scan_state_e          r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0] r_sel, w_sel_nxt;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_wrap, w_wrap_nxt;
`ifdef SCAN_BLANK_EN
  logic                 r_wrap_pend, w_wrap_pend_nxt;
`endif

  logic [SEL_WIDTH-1:0] w_next_sel;
  logic                 w_next_wrap;
  logic                 w_none;

  scan_next_sel u_next_sel (
    .i_mask  (i_mask),
    .i_sel   (r_sel),
    .i_first (r_state == ST_IDLE),
    .o_next  (w_next_sel),
    .o_wrap  (w_next_wrap),
    .o_none  (w_none)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef SCAN_BLANK_EN
      r_wrap_pend <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_wrap  <= w_wrap_nxt;
`ifdef SCAN_BLANK_EN
      r_wrap_pend <= w_wrap_pend_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_wrap_nxt  = 1'b0;
`ifdef SCAN_BLANK_EN
    w_wrap_pend_nxt = r_wrap_pend;
`endif
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
      w_en_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !w_none) begin
            w_state_nxt = ST_ACTIVE;
            w_sel_nxt   = w_next_sel;
            w_cnt_nxt   = i_period;
            w_en_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
            w_wrap_nxt  = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
          end else if (w_none) begin
            // Mask emptied during the dwell: finish here, sel holds.
            w_state_nxt = ST_IDLE;
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
          end else begin
            w_sel_nxt = w_next_sel;
`ifdef SCAN_BLANK_EN
            // sel settles during the blank cycle; wrap waits for ACTIVE.
            w_state_nxt     = ST_BLANK;
            w_en_nxt        = 1'b0;
            w_wrap_pend_nxt = w_next_wrap;
`else
            w_cnt_nxt  = i_period;
            w_wrap_nxt = w_next_wrap;
`endif
          end
        end
        ST_BLANK: begin
`ifdef SCAN_BLANK_EN
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = i_period;
          w_en_nxt    = 1'b1;
          w_wrap_nxt  = r_wrap_pend;
`else
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_en    = r_en;
  assign o_busy  = r_busy;
  assign o_wrap  = r_wrap;
  assign o_state = r_state;

endmodule
